// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
//
// Contents:
//   proto_state_t : protocol FSM states (SYNC, LEN, DATA, CSUM, DONE, ERR)
//   rx_state_t    : UART byte-engine states
//   SYNC_BYTE     : frame start marker
//   ERR_*         : err_code encodings reported by the loader
package loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } proto_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE    = 2'b00;
    localparam err_code_t ERR_FRAME   = 2'b01;
    localparam err_code_t ERR_CSUM    = 2'b10;
    localparam err_code_t ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_rx_byte.sv
// UART receive byte engine: 2-FF synchronizer on rxd followed by a
// bit-timing FSM (8N1, LSB first). A falling edge on the synchronized line
// starts a byte; the start bit is re-checked half a bit later to reject
// glitches, then data and stop bits are sampled every DIV cycles.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rxd        in   serial input, idle high, asynchronous to clk
//   byte_valid out  1-cycle pulse, byte_data holds a good byte
//   byte_data  out  received byte (valid while byte_valid is high)
//   frame_err  out  1-cycle pulse, stop bit was sampled low
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_byte: DIV must be at least 4");
    end

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_t       state;
    rx_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_d;
    logic [7:0]      shreg;
    logic [7:0]      shreg_d;
    logic            valid_d;
    logic            ferr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would chain the synchronizer
    // stages into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle-high line: presetting to 1 prevents a phantom start edge
            // right after reset.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            shreg      <= shreg_d;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
        end
    end

    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // Line back high at mid start bit: a glitch, not a byte.
                    state_d   = rx_sync ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt == DIV_M1) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_sync, shreg[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync;
                    ferr_d  = !rx_sync;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // The shift register only moves in RX_BITS, so it is stable during the
    // byte_valid pulse.
    assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader for the single-cycle CPU's instruction memory.
// Receives a frame  A5 | L | 4*L data bytes (little-endian words) | XOR
// checksum  over UART and writes each word through the memory write port.
// The CPU is held in reset until a load completes with a good checksum.
// L = 0 means a full 2**ADDR_W-word image; L above 2**ADDR_W still loads
// 2**ADDR_W words and is then reported as a checksum error.
//
// Configuration macro: LOADER_TIMEOUT_EN
//   defined   : an inter-byte timeout of TIMEOUT_CYC cycles in LEN/DATA/CSUM
//               aborts the load with err_code 11.
//   undefined : no timeout; the loader waits indefinitely.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rxd        in   UART serial input, idle high
//   imem_we    out  one-cycle instruction-memory write strobe
//   imem_addr  out  word address of the write
//   imem_wdata out  word to write
//   cpu_rst    out  1 = CPU held in reset
//   load_done  out  1 = last load completed with a good checksum
//   load_err   out  1 = last load aborted
//   err_code   out  00 none, 01 framing, 10 checksum, 11 timeout
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LEN_W = ADDR_W + 1;

    if (TIMEOUT_CYC < 1) begin : g_tmo_check
        $error("uart_prog_loader: TIMEOUT_CYC must be positive");
    end

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    proto_state_t      state,     state_d;
    logic [LEN_W-1:0]  len_words, len_d;
    logic              len_bad,   len_bad_d;
    logic [ADDR_W-1:0] word_idx,  idx_d;
    logic [1:0]        lane,      lane_d;
    logic [7:0]        acc,       acc_d;
    logic [23:0]       wbuf,      wbuf_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic              cpu_rst_d, done_d, err_d;
    err_code_t         code_d;
    logic              abort;
    err_code_t         abort_code;
    logic              tmo_hit;
    logic              in_load;

    assign in_load = (state == LEN) || (state == DATA) || (state == CSUM);

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts idle cycles between bytes; held at zero outside a load.
    always_ff @(posedge clk) begin
        if (rst || !in_load || byte_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = in_load && !byte_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            len_words  <= '0;
            len_bad    <= 1'b0;
            word_idx   <= '0;
            lane       <= '0;
            acc        <= '0;
            wbuf       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_d;
            len_words  <= len_d;
            len_bad    <= len_bad_d;
            word_idx   <= idx_d;
            lane       <= lane_d;
            acc        <= acc_d;
            wbuf       <= wbuf_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            cpu_rst    <= cpu_rst_d;
            load_done  <= done_d;
            load_err   <= err_d;
            err_code   <= code_d;
        end
    end

    always_comb begin
        state_d    = state;
        len_d      = len_words;
        len_bad_d  = len_bad;
        idx_d      = word_idx;
        lane_d     = lane;
        acc_d      = acc;
        wbuf_d     = wbuf;
        we_d       = 1'b0;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        cpu_rst_d  = cpu_rst;
        done_d     = load_done;
        err_d      = load_err;
        code_d     = err_code;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        if (in_load) begin
            if (frame_err) begin
                abort      = 1'b1;
                abort_code = ERR_FRAME;
            end else if (tmo_hit) begin
                abort      = 1'b1;
                abort_code = ERR_TIMEOUT;
            end
        end

        case (state)
            SYNC, DONE: begin
                // Framing errors and non-sync bytes are ignored while idle.
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d   = LEN;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = ERR_NONE;
                    idx_d     = '0;
                    lane_d    = '0;
                    acc_d     = '0;
                end
            end
            LEN: begin
                if (byte_valid) begin
                    len_bad_d = int'(byte_data) > DEPTH;
                    // Oversized lengths still stop at the last address; the
                    // flag turns the final checksum compare into an error.
                    if (byte_data == 8'd0 || len_bad_d) begin
                        len_d = LEN_W'(DEPTH);
                    end else begin
                        len_d = LEN_W'(byte_data);
                    end
                    state_d = DATA;
                end
            end
            DATA: begin
                if (byte_valid) begin
                    acc_d  = acc ^ byte_data;
                    lane_d = lane + 2'd1;
                    case (lane)
                        2'd0: wbuf_d[7:0]   = byte_data;
                        2'd1: wbuf_d[15:8]  = byte_data;
                        2'd2: wbuf_d[23:16] = byte_data;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = word_idx;
                            wdata_d = {byte_data, wbuf};
                            // The index stops at the last word written so it
                            // never wraps past the top of memory.
                            if ({1'b0, word_idx} + LEN_W'(1) == len_words) begin
                                state_d = CSUM;
                            end else begin
                                idx_d = word_idx + ADDR_W'(1);
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (byte_valid) begin
                    if (byte_data == acc && !len_bad) begin
                        state_d   = DONE;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_CSUM;
                    end
                end
            end
            ERR: begin
                // Error flags stay latched in SYNC until the next sync byte.
                state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase

        if (abort) begin
            state_d   = ERR;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b1;
            code_d    = abort_code;
        end
    end

endmodule
